// File: rtl/arcade_input_pkg.sv
// Shared constants for arcade_input: PS/2 key map, joystick field layout and ioctl indices.
package arcade_input_pkg;

  localparam logic [7:0] SC_P0_UP    = 8'h75;
  localparam logic [7:0] SC_P0_DOWN  = 8'h72;
  localparam logic [7:0] SC_P0_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P0_RIGHT = 8'h74;
  localparam logic [7:0] SC_P0_BTN0  = 8'h14;
  localparam logic [7:0] SC_P0_BTN1  = 8'h11;
  localparam logic [7:0] SC_P0_BTN2  = 8'h29;
  localparam logic [7:0] SC_P0_BTN3  = 8'h12;
  localparam logic [7:0] SC_P0_START = 8'h16;
  localparam logic [7:0] SC_P0_COIN  = 8'h2E;
  localparam logic [7:0] SC_P0_PAUSE = 8'h4D;

  localparam logic [7:0] SC_P1_UP    = 8'h2D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P1_LEFT  = 8'h23;
  localparam logic [7:0] SC_P1_RIGHT = 8'h34;
  localparam logic [7:0] SC_P1_BTN0  = 8'h1C;
  localparam logic [7:0] SC_P1_BTN1  = 8'h1B;
  localparam logic [7:0] SC_P1_BTN2  = 8'h15;
  localparam logic [7:0] SC_P1_BTN3  = 8'h1D;
  localparam logic [7:0] SC_P1_START = 8'h1E;
  localparam logic [7:0] SC_P1_COIN  = 8'h36;

  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_BTN0  = 4;

  localparam logic [7:0] DIP_IOCTL_INDEX  = 8'd254;
  localparam logic [7:0] GAME_IOCTL_INDEX = 8'd1;

  function automatic int unsigned idx_start(input int unsigned nb);
    return nb + 4;
  endfunction

  function automatic int unsigned idx_coin(input int unsigned nb);
    return nb + 5;
  endfunction

  function automatic int unsigned idx_pause(input int unsigned nb);
    return nb + 6;
  endfunction

  // Returns {valid, scancode} for a player's joystick field; valid=0 means no key.
  function automatic logic [8:0] key_map(input int unsigned player,
                                         input int unsigned field,
                                         input int unsigned nb);
    logic [8:0] r;
    r = '0;
    if (player == 0) begin
      if (field == JOY_RIGHT)                      r = {1'b1, SC_P0_RIGHT};
      else if (field == JOY_LEFT)                  r = {1'b1, SC_P0_LEFT};
      else if (field == JOY_DOWN)                  r = {1'b1, SC_P0_DOWN};
      else if (field == JOY_UP)                    r = {1'b1, SC_P0_UP};
      else if (field == JOY_BTN0 && nb > 0)        r = {1'b1, SC_P0_BTN0};
      else if (field == JOY_BTN0 + 1 && nb > 1)    r = {1'b1, SC_P0_BTN1};
      else if (field == JOY_BTN0 + 2 && nb > 2)    r = {1'b1, SC_P0_BTN2};
      else if (field == JOY_BTN0 + 3 && nb > 3)    r = {1'b1, SC_P0_BTN3};
      else if (field == idx_start(nb))             r = {1'b1, SC_P0_START};
      else if (field == idx_coin(nb))              r = {1'b1, SC_P0_COIN};
      else if (field == idx_pause(nb))             r = {1'b1, SC_P0_PAUSE};
    end else if (player == 1) begin
      if (field == JOY_RIGHT)                      r = {1'b1, SC_P1_RIGHT};
      else if (field == JOY_LEFT)                  r = {1'b1, SC_P1_LEFT};
      else if (field == JOY_DOWN)                  r = {1'b1, SC_P1_DOWN};
      else if (field == JOY_UP)                    r = {1'b1, SC_P1_UP};
      else if (field == JOY_BTN0 && nb > 0)        r = {1'b1, SC_P1_BTN0};
      else if (field == JOY_BTN0 + 1 && nb > 1)    r = {1'b1, SC_P1_BTN1};
      else if (field == JOY_BTN0 + 2 && nb > 2)    r = {1'b1, SC_P1_BTN2};
      else if (field == JOY_BTN0 + 3 && nb > 3)    r = {1'b1, SC_P1_BTN3};
      else if (field == idx_start(nb))             r = {1'b1, SC_P1_START};
      else if (field == idx_coin(nb))              r = {1'b1, SC_P1_COIN};
    end
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_if.sv
// ioctl download bus from hps_io; master drives, arcade_input listens.
interface arcade_input_if;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;

  modport master (output ioctl_addr, output ioctl_data, output ioctl_wr, output ioctl_index);
  modport slave  (input  ioctl_addr, input  ioctl_data, input  ioctl_wr, input  ioctl_index);
endinterface

// File: rtl/arcade_input_coin.sv
// Per-player coin shaper: one fixed-length pulse per rising edge, edges during a pulse are dropped.
module arcade_input_coin #(
  parameter int unsigned COIN_PULSE = 1600000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic coin_in,
  output logic coin_out
);
  localparam int unsigned CW = $clog2(COIN_PULSE + 1);

  logic          coin_q, coin_d;
  logic          coin_prev_q, coin_prev_d;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    coin_d      = coin_in;
    coin_prev_d = coin_q;
    cnt_d       = cnt_q;
    if (coin_q && !coin_prev_q && cnt_q == '0) begin
      cnt_d = CW'(COIN_PULSE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    out_d = (cnt_q != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coin_q      <= 1'b0;
      coin_prev_q <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
    end else begin
      coin_q      <= coin_d;
      coin_prev_q <= coin_prev_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
    end
  end

  assign coin_out = out_q;
endmodule

// File: rtl/arcade_input.sv
// Merges PS/2 keys and HPS joysticks, shapes coin/pause, captures DIP bytes and game index.
// Optional autofire on button 0 is enabled by defining ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input
  import arcade_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned NUM_DIP         = 8,
  parameter int unsigned COIN_PULSE      = 1600000,
  parameter int unsigned AUTOFIRE_CYCLES = 3200000
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [10:0]                              ps2_key,
  input  logic [NUM_PLAYERS*(NUM_BUTTONS+7)-1:0]   joystick,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [NUM_PLAYERS-1:0]                   autofire,
`endif
  arcade_input_if.slave                            ioctl,
  output logic [NUM_PLAYERS*4-1:0]                 joy,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0]       buttons,
  output logic [NUM_PLAYERS-1:0]                   start,
  output logic [NUM_PLAYERS-1:0]                   coin,
  output logic                                     pause,
  output logic [NUM_DIP*8-1:0]                     dip,
  output logic [3:0]                               game_index
);
  localparam int unsigned PW = NUM_BUTTONS + 7;
  // Key registers always cover at least players 0/1 so the key map never indexes out of range.
  localparam int unsigned KP = (NUM_PLAYERS > 2) ? NUM_PLAYERS : 2;

  logic                            old_strobe_q, old_strobe_d;
  logic                            armed_q, armed_d;
  logic                            ps2_event;
  logic [KP*PW-1:0]                key_q, key_d;
  logic [NUM_PLAYERS*PW-1:0]       merged;
  logic [NUM_PLAYERS-1:0]          fire_gate;
  logic [NUM_PLAYERS*4-1:0]        joy_q, joy_d;
  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic [NUM_PLAYERS-1:0]          start_q, start_d;
  logic                            pause_src_q, pause_src_d;
  logic                            pause_prev_q, pause_prev_d;
  logic                            pause_q, pause_d;
  logic [NUM_DIP*8-1:0]            dip_q, dip_d;
  logic [3:0]                      game_index_q, game_index_d;
  logic                            unused_ext;

  assign unused_ext = ps2_key[8];

  // armed_q masks the first cycle after reset so a high strobe at release is not an event.
  assign old_strobe_d = ps2_key[10];
  assign armed_d      = 1'b1;
  assign ps2_event    = armed_q && (old_strobe_q != ps2_key[10]);

  always_comb begin
    key_d = key_q;
    if (ps2_event) begin
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned f = 0; f < PW; f++) begin
          if (key_map(p, f, NUM_BUTTONS) == {1'b1, ps2_key[7:0]}) begin
            key_d[p*PW + f] = ps2_key[9];
          end
        end
      end
    end
  end

  always_comb begin
    merged = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      merged[p*PW +: PW] = joystick[p*PW +: PW] | key_q[p*PW +: PW];
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AW = (AUTOFIRE_CYCLES > 1) ? $clog2(AUTOFIRE_CYCLES) : 1;

  logic [AW-1:0] af_cnt_q, af_cnt_d;
  logic          af_phase_q, af_phase_d;

  always_comb begin
    af_cnt_d   = af_cnt_q + AW'(1);
    af_phase_d = af_phase_q;
    if (af_cnt_q == AW'(AUTOFIRE_CYCLES - 1)) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  assign fire_gate = ~autofire | {NUM_PLAYERS{af_phase_q}};
`else
  logic [31:0] unused_af_cycles;
  assign unused_af_cycles = AUTOFIRE_CYCLES;
  assign fire_gate        = '1;
`endif

  always_comb begin
    joy_d       = '0;
    buttons_d   = '0;
    start_d     = '0;
    pause_src_d = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      joy_d[p*4 +: 4] = {merged[p*PW + JOY_UP],    merged[p*PW + JOY_DOWN],
                         merged[p*PW + JOY_RIGHT], merged[p*PW + JOY_LEFT]};
      for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
        buttons_d[p*NUM_BUTTONS + b] = merged[p*PW + JOY_BTN0 + b] & ((b != 0) | fire_gate[p]);
      end
      start_d[p]  = merged[p*PW + idx_start(NUM_BUTTONS)];
      pause_src_d = pause_src_d | merged[p*PW + idx_pause(NUM_BUTTONS)];
    end
    pause_prev_d = pause_src_q;
    pause_d      = pause_q ^ (pause_src_q & ~pause_prev_q);
  end

  always_comb begin
    dip_d        = dip_q;
    game_index_d = game_index_q;
    if (ioctl.ioctl_wr && ioctl.ioctl_index == DIP_IOCTL_INDEX) begin
      for (int unsigned k = 0; k < NUM_DIP; k++) begin
        if (ioctl.ioctl_addr == 25'(k)) dip_d[k*8 +: 8] = ioctl.ioctl_data;
      end
    end
    if (ioctl.ioctl_wr && ioctl.ioctl_index == GAME_IOCTL_INDEX) begin
      game_index_d = ioctl.ioctl_data[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      old_strobe_q <= 1'b0;
      armed_q      <= 1'b0;
      key_q        <= '0;
      joy_q        <= '0;
      buttons_q    <= '0;
      start_q      <= '0;
      pause_src_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      pause_q      <= 1'b0;
      dip_q        <= '0;
      game_index_q <= '0;
    end else begin
      old_strobe_q <= old_strobe_d;
      armed_q      <= armed_d;
      key_q        <= key_d;
      joy_q        <= joy_d;
      buttons_q    <= buttons_d;
      start_q      <= start_d;
      pause_src_q  <= pause_src_d;
      pause_prev_q <= pause_prev_d;
      pause_q      <= pause_d;
      dip_q        <= dip_d;
      game_index_q <= game_index_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_input_coin #(
      .COIN_PULSE(COIN_PULSE)
    ) u_coin (
      .clk      (clk),
      .reset_n  (reset_n),
      .coin_in  (merged[p*PW + idx_coin(NUM_BUTTONS)]),
      .coin_out (coin[p])
    );
  end

  assign joy        = joy_q;
  assign buttons    = buttons_q;
  assign start      = start_q;
  assign pause      = pause_q;
  assign dip        = dip_q;
  assign game_index = game_index_q;
endmodule

// File: tb/tb_arcade_input.sv
// Directed self-checking bench for arcade_input (2 players, 4 buttons, 8 DIP bytes, COIN_PULSE=8).
module tb_arcade_input;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [21:0] joystick;
  logic [7:0]  joy;
  logic [7:0]  buttons;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        pause;
  logic [63:0] dip;
  logic [3:0]  game_index;
  logic        strobe;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [1:0]  autofire;
`endif

  int errors = 0;
  int checks = 0;

  arcade_input_if io_if ();

  arcade_input #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(4), .NUM_DIP(8), .COIN_PULSE(8), .AUTOFIRE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire(autofire),
`endif
    .ioctl(io_if), .joy(joy), .buttons(buttons), .start(start), .coin(coin),
    .pause(pause), .dip(dip), .game_index(game_index)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [21:0] js;
    logic        ev;
    logic [7:0]  code;
    logic        pr;
    logic        ext;
    logic [7:0]  ejoy;
    logic [7:0]  ebtn;
    logic [1:0]  est;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ps2_ev(input logic [7:0] code, input logic pr);
    strobe  = ~strobe;
    ps2_key = {strobe, pr, 1'b0, code};
  endtask

  task automatic io_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    io_if.ioctl_index = idx;
    io_if.ioctl_addr  = addr;
    io_if.ioctl_data  = data;
    io_if.ioctl_wr    = 1'b1;
    @(negedge clk);
    io_if.ioctl_wr    = 1'b0;
  endtask

  initial begin
    int hi;
    int rises;
    int c0hi;
    logic prev;
    logic seen;

    //            js        ev    code   pr    ext   joy    btn    start
    vecs[0]  = '{22'h00000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[1]  = '{22'h00001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00, 2'b00};
    vecs[2]  = '{22'h0000A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 8'h00, 2'b00};
    vecs[3]  = '{22'h02000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 2'b00};
    vecs[4]  = '{22'h40050, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h85, 2'b00};
    vecs[5]  = '{22'h80100, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2'b11};
    vecs[6]  = '{22'h00000, 1'b1, 8'h6B, 1'b1, 1'b0, 8'h01, 8'h00, 2'b00};
    vecs[7]  = '{22'h00000, 1'b1, 8'h1D, 1'b1, 1'b0, 8'h01, 8'h80, 2'b00};
    vecs[8]  = '{22'h00000, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h01, 8'h80, 2'b00};
    vecs[9]  = '{22'h00800, 1'b1, 8'h34, 1'b1, 1'b0, 8'h21, 8'h80, 2'b00};
    vecs[10] = '{22'h00000, 1'b1, 8'h6B, 1'b0, 1'b0, 8'h20, 8'h80, 2'b00};
    vecs[11] = '{22'h00000, 1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 8'h80, 2'b00};
    vecs[12] = '{22'h00000, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[13] = '{22'h00000, 1'b1, 8'h1E, 1'b1, 1'b0, 8'h00, 8'h00, 2'b10};
    vecs[14] = '{22'h00000, 1'b1, 8'h1E, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[15] = '{22'h00000, 1'b1, 8'h75, 1'b1, 1'b1, 8'h08, 8'h00, 2'b00};
    vecs[16] = '{22'h00000, 1'b1, 8'h75, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00};

    reset_n  = 1'b0;
    strobe   = 1'b0;
    ps2_key  = '0;
    joystick = '0;
    io_if.ioctl_addr  = '0;
    io_if.ioctl_data  = '0;
    io_if.ioctl_wr    = 1'b0;
    io_if.ioctl_index = '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    autofire = 2'b00;
`endif
    repeat (2) @(negedge clk);
    check("rst_joy", joy, 0);
    check("rst_buttons", buttons, 0);
    check("rst_start", start, 0);
    check("rst_coin", coin, 0);
    check("rst_pause", pause, 0);
    check("rst_dip", dip, 0);
    check("rst_game", game_index, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // PS/2 latency: visible on the second edge after the strobe change
    ps2_ev(8'h75, 1'b1);
    @(negedge clk);
    check("ps2_lat1", joy[3], 1'b0);
    @(negedge clk);
    check("ps2_lat2", joy[3], 1'b1);
    ps2_ev(8'h75, 1'b0);
    repeat (2) @(negedge clk);
    check("ps2_release", joy[3], 1'b0);

    for (int i = 0; i < 17; i++) begin
      joystick = vecs[i].js;
      if (vecs[i].ev) begin
        strobe  = ~strobe;
        ps2_key = {strobe, vecs[i].pr, vecs[i].ext, vecs[i].code};
      end
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_joy", i), joy, vecs[i].ejoy);
      check($sformatf("vec%0d_buttons", i), buttons, vecs[i].ebtn);
      check($sformatf("vec%0d_start", i), start, vecs[i].est);
    end

    // held coin: exactly one pulse of COIN_PULSE cycles
    joystick = 22'h100000;
    hi = 0; rises = 0; c0hi = 0; prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (coin[1]) hi++;
      if (coin[1] && !prev) rises++;
      if (coin[0]) c0hi++;
      prev = coin[1];
    end
    check("coin_hold_len", hi, 8);
    check("coin_hold_pulses", rises, 1);
    check("coin_other_player", c0hi, 0);
    joystick = '0;
    repeat (12) @(negedge clk);

    // re-press during the pulse must neither extend nor queue
    joystick = 22'h100000;
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (coin[1]) hi++;
      if (coin[1] && !prev) rises++;
      prev = coin[1];
      if (i == 5) joystick = '0;
      if (i == 6) joystick = 22'h100000;
    end
    check("coin_repress_len", hi, 8);
    check("coin_repress_pulses", rises, 1);
    joystick = '0;
    repeat (12) @(negedge clk);

    // pause toggling from keyboard, joystick, then both at once
    check("pause_init", pause, 1'b0);
    ps2_ev(8'h4D, 1'b1);
    repeat (4) @(negedge clk);
    ps2_ev(8'h4D, 1'b0);
    repeat (5) @(negedge clk);
    check("pause_kbd", pause, 1'b1);
    joystick = 22'h200000;
    repeat (3) @(negedge clk);
    joystick = '0;
    repeat (5) @(negedge clk);
    check("pause_joy", pause, 1'b0);
    ps2_ev(8'h4D, 1'b1);
    joystick = 22'h200000;
    repeat (4) @(negedge clk);
    ps2_ev(8'h4D, 1'b0);
    joystick = '0;
    repeat (5) @(negedge clk);
    check("pause_both", pause, 1'b1);

    // DIP and game index capture
    io_write(8'd0, 25'd0, 8'hFF);
    check("dip_wrong_index", dip, 0);
    for (int a = 0; a < 10; a++) io_write(8'd254, 25'(a), 8'hA0 + 8'(a));
    check("dip_bytes", dip, 64'hA7A6A5A4A3A2A1A0);
    check("game_untouched", game_index, 4'h0);
    io_write(8'd1, 25'd0, 8'h13);
    check("game_index", game_index, 4'h3);
    io_write(8'd0, 25'd0, 8'h0F);
    check("game_wrong_index", game_index, 4'h3);
    check("dip_after_game", dip, 64'hA7A6A5A4A3A2A1A0);

    // async reset during a coin pulse with a key held
    ps2_ev(8'h75, 1'b1);
    joystick = 22'h000200;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = coin[0];
    end
    check("coin0_seen", seen, 1'b1);
    @(negedge clk);
    check("pre_rst_joy", joy, 8'h08);
    #2 reset_n = 1'b0;
    #1;
    check("async_coin", coin, 0);
    check("async_joy", joy, 0);
    check("async_pause", pause, 0);
    check("async_dip", dip, 0);
    joystick = '0;
    strobe   = 1'b1;
    ps2_key  = {1'b1, 1'b1, 1'b0, 8'h75};
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_spurious_event", joy, 0);
    ps2_ev(8'h75, 1'b0);
    repeat (2) @(negedge clk);
    check("late_release", joy, 0);
    ps2_ev(8'h75, 1'b1);
    repeat (2) @(negedge clk);
    check("post_rst_press", joy, 8'h08);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    reset_n  = 1'b0;
    strobe   = 1'b0;
    ps2_key  = '0;
    joystick = 22'h000010;
    autofire = 2'b01;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("autofire_k%0d", k), buttons[0], (((k - 1) / 4) % 2) == 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arcade_input.md
Name: arcade_input

Overview:
- Parametrised successor to the per-core CONTROLS/DIP logic. Merges PS/2 keyboard events and HPS joysticks for NUM_PLAYERS players.
- Adds two shaping behaviours: coin pulse shaping and pause toggling.
- Captures DIP switch bytes and the game index from the ioctl stream.
- Sits between hps_io and the game core, clocked on the system clock.

Parameters:
- NUM_PLAYERS, 2: players served (1..4); keyboard map covers players 0 and 1 only.
- NUM_BUTTONS, 4: fire buttons per player (1..6).
- NUM_DIP, 8: DIP bytes captured (1..8).
- COIN_PULSE, 1600000: coin output pulse length in clk cycles (≈16.7 ms at 96 MHz); must be ≥1.
- AUTOFIRE_CYCLES, 3200000: autofire half-period in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
- joystick  in  NUM_PLAYERS*(NUM_BUTTONS+7)  per player, LSB first: right, left, down, up, buttons[NUM_BUTTONS], start, coin, pause.
- ioctl_addr  in  25  download address.
- ioctl_data  in  8  download byte.
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index.
- joy  out  NUM_PLAYERS*4  per player {up, down, right, left}.
- buttons  out  NUM_PLAYERS*NUM_BUTTONS  fire buttons.
- start  out  NUM_PLAYERS  start buttons.
- coin  out  NUM_PLAYERS  shaped coin pulses.
- pause  out  1  pause toggle level.
- dip  out  NUM_DIP*8  DIP bytes; byte k occupies [8k+7:8k].
- game_index  out  4  latched game select.

Behaviour:
- Reset: all outputs 0, all key registers 0, coin counters 0, pause 0, dip 0, game_index 0.
- PS/2 decode:
  - ps2_key[10] is registered into old_strobe; an event is old_strobe != ps2_key[10].
  - The first cycle after reset release only loads old_strobe and never produces an event.
  - The extended bit is ignored.
  - On an event, a scancode matching the key map sets or clears that key register to ps2_key[9], with the register updated in the following cycle. Unmapped codes are ignored.
- Key map:
  - P0: 75 up, 72 down, 6B left, 74 right; buttons 14, 11, 29, 12; start 16; coin 2E; pause 4D.
  - P1: 2D up, 2B down, 23 left, 34 right; buttons 1C, 1B, 15, 1D; start 1E; coin 36.
  - Buttons with index ≥4 have no key.
- Merge: merged_p = key_p | joystick_p. joy, buttons and start are registered copies of merged, giving 1 cycle latency from joystick and 2 cycles from the PS/2 strobe.
- Coin shaping, per player:
  - merged coin is registered as coin_q. On a rising edge of coin_q with counter==0, load counter=COIN_PULSE.
  - coin output = (counter != 0), registered. The counter decrements each cycle to 0.
  - A held coin gives exactly one pulse. Rising edges while counter != 0 are ignored and not queued.
- Pause:
  - pause_src = OR of all merged pause bits, registered.
  - Each rising edge of pause_src toggles pause. Simultaneous presses from several players count as one edge.
- DIP capture: when ioctl_wr && ioctl_index==254 && ioctl_addr < NUM_DIP, dip byte[ioctl_addr] <= ioctl_data. Out-of-range addresses are dropped.
- Game index: when ioctl_wr && ioctl_index==1, game_index <= ioctl_data[3:0].
- Reset mid-pulse: the pulse aborts immediately and coin drops asynchronously.
- Mid-press reset: key registers clear; a later release event is harmless.

Optional Feature:
- Macro ARCADE_INPUT_AUTOFIRE_EN.
- Defined:
  - Adds input port autofire (NUM_PLAYERS bits).
  - A free-running counter of AUTOFIRE_CYCLES toggles a shared phase bit.
  - For a player with autofire high, buttons bit 0 = merged button0 & phase.
  - phase resets to 1, so the first press fires immediately.
- Undefined: no port and no counter; buttons bit 0 passes straight through.

Decomposition:
- Package arcade_input_pkg holds:
  - scancode localparams for the key map;
  - index constants for the joystick field layout (RIGHT=0 … PAUSE=NUM_BUTTONS+6);
  - DIP_IOCTL_INDEX=254 and GAME_IOCTL_INDEX=1.
- One sub-module, arcade_input_coin: edge detector, pulse counter and output register, instantiated per player via generate.

Test Plan:
- Reset, then toggle ps2_key with code 75, pressed=1 → joy[3]=1 exactly 2 cycles after the strobe change; a second event with pressed=0 → joy[3]=0.
- Hold joystick P1 coin for 10*COIN_PULSE (COIN_PULSE=8) → coin[1] high for exactly 8 cycles, once; re-press at counter=3 → no extension.
- Keyboard pause edge, then joystick P1 pause edge 5 cycles later, then both together → pause goes 1, 0, 1.
- ioctl_index=254 writes to addr 0..9 with data 0xA0+addr, NUM_DIP=8 → dip bytes 0..7 = A0..A7; addrs 8 and 9 ignored. Write index=1 data 0x13 → game_index=3.
- Assert reset_n=0 mid coin pulse and with keys held → coin, joy and pause drop to 0 without a clock edge. Deassert with ps2_key[10]=1 → no spurious key event.
- With ARCADE_INPUT_AUTOFIRE_EN defined, AUTOFIRE_CYCLES=4, autofire[0]=1, button0 held → buttons[0] square wave of 4 cycles high / 4 cycles low, starting high.
